// File: rtl/segment_bcd_encoder_if.sv
// segment_bcd_encoder_if: valid/ready value handshake between a binary source and the encoder
interface segment_bcd_encoder_if #(
    parameter int VALUE_BITS       = 14,
    parameter int NUMBER_OF_DIGITS = 4
);
    logic                        value_valid;
    logic                        value_ready;
    logic [VALUE_BITS-1:0]       value;
    logic [NUMBER_OF_DIGITS-1:0] dp_mask;
    modport master (output value_valid, value, dp_mask, input value_ready);
    modport slave  (input value_valid, value, dp_mask, output value_ready);
endinterface

// File: rtl/segment_bcd_encoder.sv
// segment_bcd_encoder: binary -> BCD (double dabble) -> seven-segment digits, plus scan strobe; SEGMENT_BCD_LEADING_ZERO_BLANK_EN blanks leading zeros
module segment_bcd_encoder #(
    parameter int NUMBER_OF_SEGMENTS = 8,
    parameter int NUMBER_OF_DIGITS   = 4,
    parameter int VALUE_BITS         = 14,
    parameter int SCAN_DIVIDER       = 10000
) (
    input  logic                          clock,
    input  logic                          reset_n,
    segment_bcd_encoder_if.slave          bus,
    output logic [NUMBER_OF_SEGMENTS-1:0] digits [0:NUMBER_OF_DIGITS-1],
    output logic                          next_segment,
    output logic                          busy,
    output logic                          overflow
);
    localparam int BCD_BITS = 4 * NUMBER_OF_DIGITS;
    localparam int COUNT_BITS = $clog2(VALUE_BITS + 1);
    localparam int SCAN_BITS = $clog2(SCAN_DIVIDER);
    localparam longint unsigned LIMIT = 64'd10 ** NUMBER_OF_DIGITS;
    localparam bit REACHABLE = LIMIT < (64'd1 << VALUE_BITS);
    localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;
    state_t                        state, state_next;
    logic [VALUE_BITS-1:0]         shift;
    logic [BCD_BITS-1:0]           bcd, bcd_adjusted;
    logic [COUNT_BITS-1:0]         count;
    logic [NUMBER_OF_DIGITS-1:0]   dp_latched;
    logic                          overflow_pending;
    logic [SCAN_BITS-1:0]          prescaler;
    logic [NUMBER_OF_SEGMENTS-1:0] font_out [0:NUMBER_OF_DIGITS-1];
    logic                          accept;
`ifdef SEGMENT_BCD_LEADING_ZERO_BLANK_EN
    logic                          lit;
`endif

    assign bus.value_ready = state == IDLE;
    assign busy = ~bus.value_ready;
    assign accept = bus.value_ready && bus.value_valid;
    assign next_segment = prescaler == SCAN_BITS'(SCAN_DIVIDER - 1);

    // state register
    always_ff @(posedge clock)
        state <= !reset_n ? IDLE : state_next;

    // next state: accept -> VALUE_BITS shifts -> one update cycle -> idle
    always_comb begin
        state_next = state;
        if (accept)
            state_next = CONVERT;
        if (state == CONVERT && count == COUNT_BITS'(1))
            state_next = UPDATE;
        if (state == UPDATE)
            state_next = IDLE;
    end

    // add-3 correction on every nibble that would exceed 9 after the coming shift
    always_comb begin
        bcd_adjusted = bcd;
        for (int i = 0; i < NUMBER_OF_DIGITS; i++)
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adjusted[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end

    // conversion datapath: latch on accept, shift one bit per CONVERT cycle
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            shift            <= '0;
            bcd              <= '0;
            count            <= '0;
            dp_latched       <= '0;
            overflow_pending <= 1'b0;
        end else if (accept) begin
            shift            <= bus.value;
            bcd              <= '0;
            count            <= COUNT_BITS'(VALUE_BITS);
            dp_latched       <= bus.dp_mask;
            overflow_pending <= REACHABLE && (64'(bus.value) >= LIMIT);
        end else if (state == CONVERT) begin
            {bcd, shift}     <= {bcd_adjusted, shift} << 1;
            count            <= count - COUNT_BITS'(1);
        end
    end

    // font lookup, dash on overflow, dp always from the latched mask
    always_comb begin
`ifdef SEGMENT_BCD_LEADING_ZERO_BLANK_EN
        lit = 1'b0;
`endif
        for (int i = NUMBER_OF_DIGITS - 1; i >= 0; i--) begin
            font_out[i] = {dp_latched[i], overflow_pending ? 7'h40 : FONT[bcd[4*i +: 4]]};
`ifdef SEGMENT_BCD_LEADING_ZERO_BLANK_EN
            lit = lit || bcd[4*i +: 4] != 4'd0 || i == 0;
            if (!overflow_pending && !lit)
                font_out[i][6:0] = 7'h00;
`endif
        end
    end

    // display registers change only on UPDATE so partial conversions are never visible
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            digits   <= '{default: '0};
            overflow <= 1'b0;
        end else if (state == UPDATE) begin
            digits   <= font_out;
            overflow <= overflow_pending;
        end
    end

    // free-running scan prescaler, independent of conversion
    always_ff @(posedge clock)
        prescaler <= (!reset_n || next_segment) ? '0 : prescaler + SCAN_BITS'(1);
endmodule

// File: tb/tb_segment_bcd_encoder.sv
// tb_segment_bcd_encoder: table vectors, handshake sequences and randomized values against an arithmetic model
module tb_segment_bcd_encoder;
    localparam int SD = 4;
    localparam logic [6:0] FONT_REF [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct {
        logic [13:0] v;
        logic [3:0]  m;
        logic [31:0] exp;
        logic        ovf;
    } vec_t;

    logic        clock = 0;
    logic        reset_n = 0;
    logic [7:0]  digits [0:3];
    logic        next_segment, busy, overflow;
    logic [31:0] shown;
    logic [31:0] shown_exp = 0;
    logic        ovf_exp = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          tick = 0;
    vec_t        vecs [9];

    segment_bcd_encoder_if #(.VALUE_BITS(14), .NUMBER_OF_DIGITS(4)) bus ();

    segment_bcd_encoder #(
        .NUMBER_OF_SEGMENTS(8), .NUMBER_OF_DIGITS(4), .VALUE_BITS(14), .SCAN_DIVIDER(SD)
    ) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus), .digits(digits),
        .next_segment(next_segment), .busy(busy), .overflow(overflow)
    );

    always #5 clock = ~clock;
    assign shown = {digits[3], digits[2], digits[1], digits[0]};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input int v, input logic [3:0] m);
        logic [31:0] r = 0;
        int p = 1;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = {m[i], v >= 10000 ? 7'h40 : FONT_REF[(v / p) % 10]};
`ifdef SEGMENT_BCD_LEADING_ZERO_BLANK_EN
            if (v < 10000 && i > 0 && v < p)
                r[8*i +: 7] = 7'h00;
`endif
            p *= 10;
        end
        return r;
    endfunction

    // cycle index since the last reset edge: the cycle after that edge is 1
    always @(posedge clock) begin
        tick <= tick + 1;
        cyc <= !reset_n ? 1 : cyc + 1;
    end

    always @(negedge clock)
        if (cyc > 0) begin
            check("next_segment", 32'(next_segment), 32'(cyc % SD == 0));
            check("busy_is_not_ready", 32'(busy), 32'(!bus.value_ready));
        end

    task automatic accept(input logic [13:0] v, input logic [3:0] m, output int at);
        int n = 0;
        bus.value_valid = 1;
        bus.value = v;
        bus.dp_mask = m;
        while (!bus.value_ready && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (n >= 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: ready still low after %0d cycles, expected high", n);
        end
        @(posedge clock);
        at = tick;
        @(negedge clock);
    endtask

    task automatic expect_conv(input logic [31:0] exp, input logic ovf);
        for (int k = 0; k < 15; k++) begin
            check("busy_during_convert", 32'(busy), 32'd1);
            check("display_held", shown, shown_exp);
            @(negedge clock);
        end
        shown_exp = exp;
        ovf_exp = ovf;
        check("ready_after_update", 32'(bus.value_ready), 32'd1);
        check("digits", shown, shown_exp);
        check("overflow", 32'(overflow), 32'(ovf_exp));
    endtask

    initial begin
        int t1, t2, v;
        logic [3:0] m;
        vecs[0] = '{14'd1234, 4'b0100, 32'h06DB4F66, 1'b0};
        vecs[1] = '{14'd9999, 4'b1111, 32'hEFEFEFEF, 1'b0};
        vecs[2] = '{14'd1000, 4'b0001, 32'h063F3FBF, 1'b0};
        vecs[3] = '{14'd10000, 4'b0000, 32'h40404040, 1'b1};
        vecs[4] = '{14'd16383, 4'b1010, 32'hC040C040, 1'b1};
`ifdef SEGMENT_BCD_LEADING_ZERO_BLANK_EN
        vecs[5] = '{14'd42, 4'b1000, 32'h8000665B, 1'b0};
        vecs[6] = '{14'd7, 4'b0000, 32'h00000007, 1'b0};
        vecs[7] = '{14'd0, 4'b0000, 32'h0000003F, 1'b0};
        vecs[8] = '{14'd305, 4'b0000, 32'h004F3F6D, 1'b0};
`else
        vecs[5] = '{14'd42, 4'b1000, 32'hBF3F665B, 1'b0};
        vecs[6] = '{14'd7, 4'b0000, 32'h3F3F3F07, 1'b0};
        vecs[7] = '{14'd0, 4'b0000, 32'h3F3F3F3F, 1'b0};
        vecs[8] = '{14'd305, 4'b0000, 32'h3F4F3F6D, 1'b0};
`endif
        bus.value_valid = 0;
        bus.value = 0;
        bus.dp_mask = 0;
        repeat (3) @(negedge clock);
        reset_n = 1;
        check("reset_digits", shown, 32'h0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_ready", 32'(bus.value_ready), 32'd1);
        check("reset_next_segment", 32'(next_segment), 32'd0);

        foreach (vecs[i]) begin
            accept(vecs[i].v, vecs[i].m, t1);
            bus.value_valid = 0;
            expect_conv(vecs[i].exp, vecs[i].ovf);
        end

        accept(14'd5, 4'b0000, t1);
        bus.value = 14'd9;
        expect_conv(model(5, 4'b0000), 1'b0);
        accept(14'd9, 4'b0000, t2);
        bus.value_valid = 0;
        check("back_to_back_gap", t2 - t1, 32'd16);
        expect_conv(model(9, 4'b0000), 1'b0);

        repeat (40) begin
            case ($urandom_range(0, 3))
                0: v = $urandom_range(0, 99);
                1: v = $urandom_range(9990, 10010);
                default: v = $urandom_range(0, 16383);
            endcase
            m = 4'($urandom_range(0, 15));
            repeat ($urandom_range(0, 3)) @(negedge clock);
            accept(14'(v), m, t1);
            bus.value_valid = 0;
            expect_conv(model(v, m), v >= 10000);
        end

        accept(14'd1234, 4'b1111, t1);
        bus.value_valid = 0;
        repeat (5) @(negedge clock);
        reset_n = 0;
        @(negedge clock);
        reset_n = 1;
        shown_exp = 0;
        ovf_exp = 0;
        check("abort_digits", shown, 32'h0);
        check("abort_overflow", 32'(overflow), 32'd0);
        check("abort_ready", 32'(bus.value_ready), 32'd1);
        repeat (3) @(negedge clock);
        check("abort_display_stays", shown, 32'h0);
        accept(14'd77, 4'b0010, t1);
        bus.value_valid = 0;
        expect_conv(model(77, 4'b0010), 1'b0);
        repeat (10) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/segment_bcd_encoder.md
# segment_bcd_encoder

Converts a binary value into per-digit seven-segment patterns and produces the digit-advance strobe for the multiplexed segment LED scanner that sits directly downstream. A value is accepted over a valid/ready handshake, converted to BCD by a sequential double-dabble engine (one shift per clock), font-encoded, and held in the `digits` register array until the next value is accepted. A free-running prescaler produces the scanner's `next_segment` pulse independently of conversion.

## Interface
- `NUMBER_OF_SEGMENTS`, 8: segment bits per digit. Fixed at 8: bit0=a … bit6=g, bit7=dp.
- `NUMBER_OF_DIGITS`, 4: display digits; `digits[0]` is the least significant.
- `VALUE_BITS`, 14: width of the binary input.
- `SCAN_DIVIDER`, 10000: clock cycles per `next_segment` pulse; must be ≥2.

Ports:
- `clock`  in  1: single clock, all logic on the rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `value_valid`  in  1: `value` and `dp_mask` are presented.
- `value_ready`  out  1: the block can accept a value; high exactly when the state is IDLE.
- `value`  in  VALUE_BITS: unsigned binary to display.
- `dp_mask`  in  NUMBER_OF_DIGITS: bit i lights the dp of digit i.
- `digits`  out  [NUMBER_OF_SEGMENTS-1:0] x [0:NUMBER_OF_DIGITS-1]: registered, active-high segment patterns.
- `next_segment`  out  1: one-cycle scan strobe.
- `busy`  out  1: equal to `~value_ready`.
- `overflow`  out  1: the last accepted value was ≥ 10**NUMBER_OF_DIGITS.

## Operation
- States:
  - IDLE: `value_ready`=1. When `value_valid`=1, the block latches `value` and `dp_mask`, clears the BCD register, sets the iteration counter to VALUE_BITS, and goes to CONVERT.
  - CONVERT: each cycle, every BCD nibble ≥5 gets +3, then {bcd, shift} is shifted left by 1 with the value MSB entering. The counter decrements. After VALUE_BITS shifts the state goes to UPDATE.
  - UPDATE: the font is applied and `digits` and `overflow` are written. Next state is IDLE.
- BCD register width is 4*NUMBER_OF_DIGITS. Bits shifted out of the top are discarded; this only occurs in the overflow case.
- Overflow is decided at accept by comparing `value` ≥ 10**NUMBER_OF_DIGITS, with the constant evaluated at VALUE_BITS+1 bits. If VALUE_BITS cannot reach that constant, `overflow` stays 0.
- Font: 0→0x3F, 1→0x06, 2→0x5B, 3→0x4F, 4→0x66, 5→0x6D, 6→0x7D, 7→0x07, 8→0x7F, 9→0x6F. On overflow, every digit is 0x40 (dash).
- bit7 of `digits[i]` = `dp_mask[i]`. This applies to all digits, including blanked and dashed ones.
- `value_valid` while busy is not accepted. The source must hold `value_valid` and data until it sees `value_ready`.
- Scan prescaler: a counter runs 0..SCAN_DIVIDER-1 and wraps. `next_segment`=1 in the cycle the counter equals SCAN_DIVIDER-1. The prescaler is unaffected by conversion state.

## Timing
- Reset (`reset_n`=0 at an edge):
  - state goes to IDLE; `value_ready`=1 after that edge;
  - all `digits` = 0x00;
  - `overflow`=0, `next_segment`=0, prescaler=0.
- Handshakes at an edge where `reset_n`=0 are ignored.
- Latency: for an accept at edge E0, `digits`/`overflow` update at edge E0+VALUE_BITS+1. `value_ready` returns high after that same edge. The next accept can occur at edge E0+VALUE_BITS+2.
- `digits` changes only at the UPDATE edge or at reset. It never shows partial conversions.
- Reset mid-CONVERT aborts the conversion. All outputs take their reset values and the latched value is lost.
- First `next_segment` pulse is in the SCAN_DIVIDER-th cycle after reset release. Subsequent pulses come every SCAN_DIVIDER cycles.

## Configuration
- Macro: `SEGMENT_BCD_LEADING_ZERO_BLANK_EN`.
- Defined: digits above the most significant nonzero digit output 0x00 (plus their dp bit). `digits[0]` is always shown, so value 0 displays "0". Blanking does not apply on overflow.
- Undefined: all digits are shown, including leading zeros.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles, then release → all `digits`=0x00, `overflow`=0, `value_ready`=1, `next_segment`=0.
- Value 1234, dp_mask=4'b0100 → exactly 15 cycles after accept: `digits[3..0]` = 0x06, 0xDB, 0x4F, 0x66; `overflow`=0.
- Value 7, dp_mask=0 → with the macro, `digits[0]`=0x07 and the others are 0x00. Without it, the others are 0x3F. Value 0 with the macro → `digits[0]`=0x3F.
- Value 10000 (and 16383) → all digits 0x40, `overflow`=1. A following value 42 clears `overflow` and shows 42.
- Back-to-back: hold `value_valid` with 5 then 9 → the second value is accepted only at the first edge with `value_ready`=1 (E0+16). The final display is 9. `busy` is high for 15 cycles per conversion.
- SCAN_DIVIDER=4 → `next_segment` is high in cycles 4, 8, 12 after reset, regardless of conversions. Asserting `reset_n`=0 mid-CONVERT → `digits` go to 0x00, and the prescaler restarts.
